// File: rtl/idli_iq_m.sv
// idli_iq_m: instruction queue between the SQI fetch path and decode.
//
// Each 16b instruction that the SQI block delivers at the end of a 4-GCK slot
// (&i_iq_ctr) is stored with its fetch PC. The oldest entry is presented to
// decode. While the queue is full the SQI clock is stalled. A flush discards
// every entry and reloads the fetch PC.
//
// Optional feature macro: IDLI_IQ_BYPASS_EN
//   Defined   - an instruction arriving while the queue is empty is shown on the
//               head outputs in the same cycle. If decode pops it in that same
//               cycle it is never written.
//   Undefined - head outputs come from stored entries only (one-GCK latency).
//
// Handshake: a slot-end transfer happens when the producer has i_iq_instr_vld=1
// and o_iq_stall=0. A consumer transfer happens when o_iq_vld=1 and i_iq_pop=1
// at a slot end. Neither side may assume a transfer outside a slot end, and
// i_iq_flush cancels both transfers in its slot.

module idli_iq_m #(
  parameter int DEPTH = 2
) (
  input  logic        i_iq_gck,
  input  logic        i_iq_rst,
  input  logic [1:0]  i_iq_ctr,
  input  logic [15:0] i_iq_instr,
  input  logic        i_iq_instr_vld,
  input  logic        i_iq_flush,
  input  logic [15:0] i_iq_redirect_pc,
  input  logic        i_iq_pop,
  output logic        o_iq_stall,
  output logic        o_iq_vld,
  output logic [15:0] o_iq_instr,
  output logic [15:0] o_iq_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [15:0]        fetch_pc_q;
  logic               stall_q;

  logic               slot_end;
  logic               head_vld;
  logic               push_req;
  logic               pop_req;
  logic               write_en;
  logic               pop_stored;
  entry_t             head;

  assign slot_end = &i_iq_ctr;
  assign head_vld = (count_q != '0);
  assign head     = entries[rd_ptr];

  // A stalled slot carries a stale repeat of the previous instruction, so it
  // never counts as a push.
  assign push_req = slot_end && i_iq_instr_vld && !stall_q && !i_iq_flush;

`ifdef IDLI_IQ_BYPASS_EN
  logic bypass;

  // Empty queue plus an arriving instruction: forward it straight to decode.
  assign bypass     = push_req && (count_q == '0);
  assign o_iq_vld   = head_vld || bypass;
  assign o_iq_instr = bypass ? i_iq_instr : head.instr;
  assign o_iq_pc    = bypass ? fetch_pc_q : head.pc;
  assign pop_req    = slot_end && i_iq_pop && o_iq_vld && !i_iq_flush;
  // A forwarded instruction consumed in the same cycle never occupies a slot.
  assign write_en   = push_req && !(bypass && pop_req);
  assign pop_stored = pop_req && head_vld;
`else
  assign o_iq_vld   = head_vld;
  assign o_iq_instr = head.instr;
  assign o_iq_pc    = head.pc;
  assign pop_req    = slot_end && i_iq_pop && head_vld && !i_iq_flush;
  assign write_en   = push_req;
  assign pop_stored = pop_req;
`endif

  assign o_iq_stall = stall_q;

  // Next occupancy: flush empties, simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (i_iq_flush) begin
      count_d = '0;
    end else begin
      case ({write_en, pop_stored})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers, occupancy, fetch PC and stall, updated at slot end.
  always_ff @(posedge i_iq_gck or posedge i_iq_rst) begin
    if (i_iq_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      fetch_pc_q <= 16'h0000;
      stall_q    <= 1'b0;
    end else if (slot_end) begin
      count_q <= count_d;
      stall_q <= (count_d == CNT_W'(DEPTH));
      if (i_iq_flush) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fetch_pc_q <= i_iq_redirect_pc;
      end else begin
        if (write_en) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop_stored) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        // The PC advances for every accepted instruction, including one that
        // was forwarded and consumed without being stored.
        if (push_req) begin
          fetch_pc_q <= fetch_pc_q + 16'd1;
        end
      end
    end
  end

  // Entry storage: tag the incoming instruction with the current fetch PC.
  always_ff @(posedge i_iq_gck or posedge i_iq_rst) begin
    if (i_iq_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (write_en) begin
      entries[wr_ptr] <= '{instr: i_iq_instr, pc: fetch_pc_q};
    end
  end

  // Occupancy can never exceed DEPTH because pushes are blocked while full.
  always @(posedge i_iq_gck) begin
    if (!i_iq_rst) begin
      assert (count_q <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_idli_iq_m.sv
// Directed testbench for idli_iq_m (DEPTH=2). Covers reset, push latency,
// fill/stall, push+pop in one slot, flush with PC wrap, off-slot inputs,
// flush beating push, the same-cycle forwarding path (IDLI_IQ_BYPASS_EN) or
// its absence, and asynchronous reset mid-slot.

module tb_idli_iq_m;

  logic        clk;
  logic        rst;
  logic [1:0]  ctr;
  logic [15:0] instr;
  logic        instr_vld;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        pop;
  logic        stall;
  logic        vld;
  logic [15:0] head_instr;
  logic [15:0] head_pc;

  int checks   = 0;
  int failures = 0;

  idli_iq_m #(.DEPTH(2)) dut (
    .i_iq_gck         (clk),
    .i_iq_rst         (rst),
    .i_iq_ctr         (ctr),
    .i_iq_instr       (instr),
    .i_iq_instr_vld   (instr_vld),
    .i_iq_flush       (flush),
    .i_iq_redirect_pc (redirect_pc),
    .i_iq_pop         (pop),
    .o_iq_stall       (stall),
    .o_iq_vld         (vld),
    .o_iq_instr       (head_instr),
    .o_iq_pc          (head_pc)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_vld   = 1'b0;
    instr       = 16'h0000;
    pop         = 1'b0;
    flush       = 1'b0;
    redirect_pc = 16'h0000;
  endtask

  // One full slot; the given inputs are presented only in the ctr=3 cycle.
  // Returns just after the slot-end edge, in the first cycle of the next slot.
  task automatic run_slot(input logic v, input logic [15:0] ins, input logic p,
                          input logic f, input logic [15:0] rpc);
    clear_inputs();
    ctr = 2'd0; tick();
    ctr = 2'd1; tick();
    ctr = 2'd2; tick();
    ctr = 2'd3;
    instr_vld = v; instr = ins; pop = p; flush = f; redirect_pc = rpc;
    tick();
    clear_inputs();
    ctr = 2'd0;
  endtask

  task automatic push(input logic [15:0] ins);
    run_slot(1'b1, ins, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_pop();
    run_slot(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic push_pop(input logic [15:0] ins);
    run_slot(1'b1, ins, 1'b1, 1'b0, 16'h0000);
  endtask

  initial begin
    // Reset
    clear_inputs();
    ctr = 2'd0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_vld",   vld,        16'h0);
    chk("rst_instr", head_instr, 16'h0000);
    chk("rst_pc",    head_pc,    16'h0000);
    chk("rst_stall", stall,      16'h0);
    rst = 1'b0;
    tick();

    // First push after reset is tagged PC 0 and visible one GCK later
    push(16'h1234);
    chk("p1_vld",   vld,        16'h1);
    chk("p1_instr", head_instr, 16'h1234);
    chk("p1_pc",    head_pc,    16'h0000);
    chk("p1_stall", stall,      16'h0);

    // Second push fills the queue
    push(16'h2222);
    chk("full_stall", stall,      16'h1);
    chk("full_head",  head_instr, 16'h1234);

    // Push while stalled is a stale repeat and is dropped
    push(16'h3333);
    chk("stale_stall", stall,   16'h1);
    chk("stale_pc",    head_pc, 16'h0000);

    // Pop releases the stall in the following slot
    do_pop();
    chk("pop_stall", stall,      16'h0);
    chk("pop_instr", head_instr, 16'h2222);
    chk("pop_pc",    head_pc,    16'h0001);

    // Push and pop together: count stays 1, pointers wrap
    push_pop(16'h3333);
    chk("pp1_instr", head_instr, 16'h3333);
    chk("pp1_pc",    head_pc,    16'h0002);
    chk("pp1_stall", stall,      16'h0);
    push_pop(16'h4444);
    chk("pp2_instr", head_instr, 16'h4444);
    chk("pp2_pc",    head_pc,    16'h0003);

    // Refill, then push+pop while full: push is blocked, pop proceeds
    push(16'h5555);
    chk("refill_stall", stall, 16'h1);
    push_pop(16'h6666);
    chk("fullpp_instr", head_instr, 16'h5555);
    chk("fullpp_pc",    head_pc,    16'h0004);
    chk("fullpp_stall", stall,      16'h0);

    // Flush while full, redirect to 0xFFFF, PC wraps to 0x0000
    push(16'h6666);
    chk("pre_flush_stall", stall, 16'h1);
    run_slot(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    chk("flush_vld",   vld,   16'h0);
    chk("flush_stall", stall, 16'h0);
    push(16'hA000);
    chk("wrap0_instr", head_instr, 16'hA000);
    chk("wrap0_pc",    head_pc,    16'hFFFF);
    push(16'hA001);
    do_pop();
    chk("wrap1_instr", head_instr, 16'hA001);
    chk("wrap1_pc",    head_pc,    16'h0000);
    do_pop();
    chk("drain_vld", vld, 16'h0);

    // Pop while empty is ignored
    do_pop();
    chk("empty_pop_vld", vld, 16'h0);
    push(16'hB000);
    chk("after_empty_pc", head_pc, 16'h0001);

    // Pop and valid pulsed at ctr=1 change nothing
    clear_inputs();
    ctr = 2'd0; tick();
    ctr = 2'd1; instr_vld = 1'b1; instr = 16'hDEAD; pop = 1'b1; tick();
    clear_inputs();
    ctr = 2'd2; tick();
    ctr = 2'd3; tick();
    ctr = 2'd0;
    chk("ctr1_vld",   vld,        16'h1);
    chk("ctr1_instr", head_instr, 16'hB000);
    chk("ctr1_stall", stall,      16'h0);

    // Flush coincident with push: push dropped, PC reloaded
    run_slot(1'b1, 16'hC000, 1'b0, 1'b1, 16'h0100);
    chk("flushpush_vld", vld, 16'h0);
    push(16'hC001);
    chk("flushpush_instr", head_instr, 16'hC001);
    chk("flushpush_pc",    head_pc,    16'h0100);
    do_pop();
    chk("empty_again_vld", vld, 16'h0);

    // Empty queue: push 0xBEEF and pop in the same slot-end cycle
    clear_inputs();
    ctr = 2'd0; tick();
    ctr = 2'd1; tick();
    ctr = 2'd2; tick();
    ctr = 2'd3; instr_vld = 1'b1; instr = 16'hBEEF; pop = 1'b1;
    #1;
`ifdef IDLI_IQ_BYPASS_EN
    chk("byp_now_vld",   vld,        16'h1);
    chk("byp_now_instr", head_instr, 16'hBEEF);
    chk("byp_now_pc",    head_pc,    16'h0101);
`else
    chk("nobyp_now_vld", vld, 16'h0);
`endif
    tick();
    clear_inputs();
    ctr = 2'd0;
`ifdef IDLI_IQ_BYPASS_EN
    chk("byp_after_vld", vld, 16'h0);
    push(16'hD000);
    chk("byp_next_pc",    head_pc,    16'h0102);
    chk("byp_next_stall", stall,      16'h0);
`else
    chk("nobyp_after_vld",   vld,        16'h1);
    chk("nobyp_after_instr", head_instr, 16'hBEEF);
    chk("nobyp_after_pc",    head_pc,    16'h0101);
    push(16'hD000);
    chk("nobyp_next_stall", stall, 16'h1);
`endif
    chk("pre_rst_vld", vld, 16'h1);

    // Asynchronous reset in the middle of a slot clears outputs at once
    ctr = 2'd0; tick();
    ctr = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_vld",   vld,        16'h0);
    chk("async_instr", head_instr, 16'h0000);
    chk("async_pc",    head_pc,    16'h0000);
    chk("async_stall", stall,      16'h0);
    tick();
    ctr = 2'd0;
    rst = 1'b0;
    tick();
    push(16'h1111);
    chk("post_rst_instr", head_instr, 16'h1111);
    chk("post_rst_pc",    head_pc,    16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
